// File: rtl/ram_seq_reader.sv
// Walks a synchronous single-port RAM from a latched base/count/stride and
// streams each word out over a valid/ready interface.
module ram_seq_reader #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned RD_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   count,
   input  logic [ADDR_W-1:0] stride,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W:0]   out_index,
   output logic              busy,
   output logic              done
);

   localparam int unsigned CNT_W  = ADDR_W + 1;
   localparam int unsigned WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_PRESENT,
      S_DONE
   } state_t;

   state_t              r_state,     w_state_nxt;
   logic [ADDR_W-1:0]   r_cur_addr,  w_cur_addr_nxt;
   logic [CNT_W-1:0]    r_count,     w_count_nxt;
   logic [ADDR_W-1:0]   r_stride,    w_stride_nxt;
   logic [CNT_W-1:0]    r_idx,       w_idx_nxt;
   logic [WAIT_W-1:0]   r_wait,      w_wait_nxt;
   logic [ADDR_W-1:0]   r_mem_addr,  w_mem_addr_nxt;
   logic [DATA_W-1:0]   r_out_data,  w_out_data_nxt;
   logic                r_out_valid, w_out_valid_nxt;
   logic [CNT_W-1:0]    r_out_index, w_out_index_nxt;
   logic                r_busy,      w_busy_nxt;
   logic                r_done,      w_done_nxt;

   // State and datapath registers; reset clears every output.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cur_addr  <= '0;
         r_count     <= '0;
         r_stride    <= '0;
         r_idx       <= '0;
         r_wait      <= '0;
         r_mem_addr  <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_out_index <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cur_addr  <= w_cur_addr_nxt;
         r_count     <= w_count_nxt;
         r_stride    <= w_stride_nxt;
         r_idx       <= w_idx_nxt;
         r_wait      <= w_wait_nxt;
         r_mem_addr  <= w_mem_addr_nxt;
         r_out_data  <= w_out_data_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_out_index <= w_out_index_nxt;
         r_busy      <= w_busy_nxt;
         r_done      <= w_done_nxt;
      end
   end

   // Next-state and next-output logic; everything holds unless a state acts.
   always_comb begin
      w_state_nxt     = r_state;
      w_cur_addr_nxt  = r_cur_addr;
      w_count_nxt     = r_count;
      w_stride_nxt    = r_stride;
      w_idx_nxt       = r_idx;
      w_wait_nxt      = r_wait;
      w_mem_addr_nxt  = r_mem_addr;
      w_out_data_nxt  = r_out_data;
      w_out_valid_nxt = r_out_valid;
      w_out_index_nxt = r_out_index;
      w_busy_nxt      = r_busy;
      w_done_nxt      = r_done;

      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_cur_addr_nxt = base_addr;
               w_count_nxt    = count;
               w_stride_nxt   = stride;
               w_idx_nxt      = '0;
               w_done_nxt     = 1'b0;
               if (count == '0) begin
                  // Empty request completes immediately without ever going busy.
                  w_state_nxt = S_DONE;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_busy_nxt  = 1'b1;
                  w_state_nxt = S_ISSUE;
               end
            end
         end

         S_ISSUE: begin
            w_mem_addr_nxt = r_cur_addr;
            w_wait_nxt     = WAIT_W'(RD_LAT - 1);
            w_state_nxt    = S_WAIT;
         end

         S_WAIT: begin
            if (r_wait == '0) begin
               w_out_data_nxt  = mem_rdata;
               w_out_index_nxt = r_idx;
               w_out_valid_nxt = 1'b1;
               w_state_nxt     = S_PRESENT;
            end else begin
               w_wait_nxt = r_wait - WAIT_W'(1);
            end
         end

         S_PRESENT: begin
            if (r_out_valid && out_ready) begin
               w_out_valid_nxt = 1'b0;
               w_idx_nxt       = r_idx + CNT_W'(1);
               w_cur_addr_nxt  = r_cur_addr + r_stride;
               if ((r_idx + CNT_W'(1)) == r_count) begin
                  w_state_nxt = S_DONE;
                  w_busy_nxt  = 1'b0;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_state_nxt = S_ISSUE;
               end
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign mem_addr  = r_mem_addr;
   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign out_index = r_out_index;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule

// File: tb/tb_ram_seq_reader.sv
// Scoreboard bench for ram_seq_reader: directed sequences push expected words,
// a negedge monitor pops and compares on every handshake.
module tb_ram_seq_reader;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 4;
   localparam int unsigned RD_LAT = 2;

   typedef struct packed {
      logic [DATA_W-1:0] d;
      logic [ADDR_W:0]   idx;
      logic [ADDR_W-1:0] a;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [ADDR_W:0]   count = '0;
   logic [ADDR_W-1:0] stride = '0;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rdata = '0;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [ADDR_W:0]   out_index;
   logic              busy;
   logic              done;

   logic [DATA_W-1:0] ram [16];
   exp_t              sb_q[$];
   int                n_checks = 0;
   int                n_fail = 0;
   int                n_popped = 0;

   ram_seq_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .count(count), .stride(stride), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_index(out_index), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // RAM model: one pipeline stage after the registered address.
   always @(posedge clk) mem_rdata <= ram[mem_addr];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: stall stability and scoreboard pop on each handshake.
   logic              prev_valid = 1'b0;
   logic              prev_ready = 1'b0;
   logic [DATA_W-1:0] prev_data;
   logic [ADDR_W:0]   prev_idx;
   logic [ADDR_W-1:0] prev_addr;
   always @(negedge clk) begin
      if (rst) begin
         prev_valid = 1'b0;
      end else begin
         if (prev_valid && !prev_ready) begin
            check("valid_held", 64'(out_valid), 64'd1);
            check("stall_data", 64'(out_data), 64'(prev_data));
            check("stall_index", 64'(out_index), 64'(prev_idx));
            check("stall_addr", 64'(mem_addr), 64'(prev_addr));
         end
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               check("unexpected_word", 64'(out_index), 64'h1_0000_0000);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               n_popped++;
               check("out_data", 64'(out_data), 64'(e.d));
               check("out_index", 64'(out_index), 64'(e.idx));
               check("mem_addr", 64'(mem_addr), 64'(e.a));
            end
         end
         prev_valid = out_valid;
         prev_ready = out_ready;
         prev_data  = out_data;
         prev_idx   = out_index;
         prev_addr  = mem_addr;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start for one edge and queue the words it should produce.
   task automatic start_seq(input int b, input int c, input int s);
      for (int i = 0; i < c; i++) begin
         exp_t e;
         e.a   = ADDR_W'((b + i * s) % 16);
         e.d   = ram[e.a];
         e.idx = (ADDR_W+1)'(i);
         sb_q.push_back(e);
      end
      base_addr = ADDR_W'(b);
      count     = (ADDR_W+1)'(c);
      stride    = ADDR_W'(s);
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   task automatic wait_done(input string name, input int limit);
      int k;
      k = 0;
      while (!done && k < limit) begin
         tick();
         k++;
      end
      check(name, 64'(done), 64'd1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
      check({tag, "_out_data"}, 64'(out_data), 64'd0);
      check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_out_index"}, 64'(out_index), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int per;
      for (int i = 0; i < 16; i++) ram[i] = DATA_W'(i * 32'h1111);

      // Reset from idle.
      tick();
      tick();
      rst = 1'b0;
      check_all_zero("rst_idle");

      // Basic 12-word dump with latency and period measurement.
      out_ready = 1'b1;
      start_seq(0, 12, 1);
      check("busy_after_start", 64'(busy), 64'd1);
      check("done_cleared", 64'(done), 64'd0);
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      check("first_latency", 64'(lat), 64'(RD_LAT + 1));
      per = 0;
      do begin
         tick();
         per++;
      end while (!out_valid && per < 20);
      check("word_period", 64'(per), 64'(RD_LAT + 2));
      wait_done("dump_done", 200);
      check("dump_busy", 64'(busy), 64'd0);
      check("dump_valid", 64'(out_valid), 64'd0);
      check("dump_words", 64'(n_popped), 64'd12);
      check("dump_q_empty", 64'(sb_q.size()), 64'd0);

      // Stride with address wrap: 14, 1, 4, 7.
      start_seq(14, 4, 3);
      wait_done("stride_done", 100);
      check("stride_words", 64'(n_popped), 64'd16);

      // Backpressure on word 2 for five cycles.
      start_seq(0, 5, 1);
      lat = 0;
      while (!(out_valid && out_index == 5'd2) && lat < 100) begin
         tick();
         lat++;
      end
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_valid", 64'(out_valid), 64'd1);
         check("bp_index", 64'(out_index), 64'd2);
         check("bp_addr", 64'(mem_addr), 64'd2);
         check("bp_data", 64'(out_data), 64'h2222);
      end
      out_ready = 1'b1;
      wait_done("bp_done", 100);
      check("bp_words", 64'(n_popped), 64'd21);

      // Zero count completes at once; a following start clears done.
      start_seq(3, 0, 1);
      check("zero_done", 64'(done), 64'd1);
      check("zero_busy", 64'(busy), 64'd0);
      check("zero_valid", 64'(out_valid), 64'd0);
      tick();
      tick();
      check("zero_busy_later", 64'(busy), 64'd0);
      start_seq(5, 3, 2);
      check("restart_done_clr", 64'(done), 64'd0);
      wait_done("restart_done", 100);
      check("restart_words", 64'(n_popped), 64'd24);

      // Start pulsed during WAIT is ignored.
      start_seq(4, 3, 1);
      tick();
      base_addr = 4'd9;
      count     = 5'd7;
      stride    = 4'd5;
      start     = 1'b1;
      tick();
      start     = 1'b0;
      wait_done("ign_done", 100);
      check("ign_words", 64'(n_popped), 64'd27);
      check("ign_q_empty", 64'(sb_q.size()), 64'd0);

      // Reset mid-sequence aborts and stays quiet.
      start_seq(0, 12, 1);
      for (int i = 0; i < 6; i++) tick();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      sb_q.delete();
      check_all_zero("rst_mid");
      for (int i = 0; i < 8; i++) begin
         tick();
         check("post_rst_valid", 64'(out_valid), 64'd0);
         check("post_rst_done", 64'(done), 64'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
